// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg: shared widths, field offsets and state type for the TileLink
// acquire arbiter.
//   Acquire packing (114b, high->low): header_src 2, header_dst 2,
//     addr_block 26, client_xact_id 1, addr_beat 3, is_builtin_type 1,
//     a_type 3, union 12, data 64.
//   Grant packing (79b, high->low): src 2, dst 2, addr_beat 3,
//     client_xact_id 1, manager_xact_id 2, is_builtin_type 1, g_type 4, data 64.
package tl_arb_pkg;

  localparam int unsigned ACQ_W = 114;
  localparam int unsigned GNT_W = 79;

  localparam int unsigned ACQ_HDR_SRC_LSB = 112;
  localparam int unsigned ACQ_HDR_DST_LSB = 110;
  localparam int unsigned ACQ_BUILTIN_BIT = 79;
  localparam int unsigned ACQ_A_TYPE_LSB  = 76;

  localparam int unsigned GNT_DST_LSB = 75;

  localparam logic [2:0] A_TYPE_PUT_BLOCK = 3'd3;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  // Built-in PutBlock is the only multi-beat acquire.
  function automatic logic is_multi_beat(input logic [ACQ_W-1:0] bits);
    return bits[ACQ_BUILTIN_BIT] &&
           (bits[ACQ_A_TYPE_LSB +: 3] == A_TYPE_PUT_BLOCK);
  endfunction

endpackage

// File: rtl/tl_arb_skid_fifo.sv
// tl_arb_skid_fifo: 2-entry FIFO placed between the arbiter and the manager
// acquire port when TL_ARB_PIPE_EN is defined. Full throughput, one cycle of
// latency, cleared on reset.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_bits    : push side (arbiter)
//   out_valid/out_ready/out_bits : pop side (manager acquire port)
module tl_arb_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_bits  = rptr ? mem1 : mem0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !wptr) mem0 <= in_bits;
    if (push &&  wptr) mem1 <= in_bits;
  end

endmodule

// File: rtl/tl_acquire_arbiter.sv
// tl_acquire_arbiter: shares one TileLink manager port between N_CLIENTS
// clients. Acquires are round-robin arbitrated (locked to one client for a
// full PutBlock burst); grants are demultiplexed back by header dst.
// Optional build macro: TL_ARB_PIPE_EN inserts a 2-entry FIFO on mg_acq_*.
//   clk, reset (async, active-low)
//   cl_acq_valid/ready/bits : per-client acquire (client i at bits [i*114 +: 114])
//   mg_acq_valid/ready/bits : manager acquire, header_src = winning client
//   mg_gnt_valid/ready/bits : manager grant
//   cl_gnt_valid/ready      : per-client grant handshake; cl_gnt_bits broadcast
//   arb_locked              : a multi-beat burst owns the port
//   arb_owner               : current/last winner
module tl_acquire_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned BEATS     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CLIENTS-1:0]       cl_acq_valid,
  output logic [N_CLIENTS-1:0]       cl_acq_ready,
  input  logic [N_CLIENTS*ACQ_W-1:0] cl_acq_bits,
  output logic                       mg_acq_valid,
  input  logic                       mg_acq_ready,
  output logic [ACQ_W-1:0]           mg_acq_bits,
  input  logic                       mg_gnt_valid,
  output logic                       mg_gnt_ready,
  input  logic [GNT_W-1:0]           mg_gnt_bits,
  output logic [N_CLIENTS-1:0]       cl_gnt_valid,
  input  logic [N_CLIENTS-1:0]       cl_gnt_ready,
  output logic [GNT_W-1:0]           cl_gnt_bits,
  output logic                       arb_locked,
  output logic [1:0]                 arb_owner
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  arb_state_e       state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [1:0]       win;
  logic             any_valid;
  logic [1:0]       sel;
  logic             sel_valid;
  logic [ACQ_W-1:0] sel_bits;
  logic [ACQ_W-1:0] arb_bits;
  logic             arb_valid;
  logic             dn_ready;
  logic             fire;
  logic [1:0]       gnt_dst;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(N_CLIENTS - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin search: first valid client at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      for (int unsigned j = 0; j < N_CLIENTS; j++) begin
        if (!any_valid && (idx == j) && cl_acq_valid[j]) begin
          any_valid = 1'b1;
          win       = 2'(j);
        end
      end
    end
  end

  // While locked only the burst owner is eligible; nobody else may interleave.
  assign sel = (state == LOCKED) ? arb_owner : win;

  always_comb begin
    sel_valid = 1'b0;
    sel_bits  = '0;
    for (int unsigned j = 0; j < N_CLIENTS; j++) begin
      if (sel == 2'(j)) begin
        sel_valid = cl_acq_valid[j];
        sel_bits  = cl_acq_bits[j*ACQ_W +: ACQ_W];
      end
    end
  end

  always_comb begin
    arb_bits = sel_bits;
    arb_bits[ACQ_HDR_SRC_LSB +: 2] = sel;
  end

  assign arb_valid = reset & sel_valid;
  assign fire      = arb_valid & dn_ready;

  always_comb begin
    cl_acq_ready = '0;
    for (int unsigned j = 0; j < N_CLIENTS; j++) begin
      cl_acq_ready[j] = (sel == 2'(j)) & arb_valid & dn_ready;
    end
  end

`ifdef TL_ARB_PIPE_EN
  logic fifo_in_ready;

  tl_arb_skid_fifo #(
    .WIDTH (ACQ_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (arb_valid),
    .in_ready  (fifo_in_ready),
    .in_bits   (arb_bits),
    .out_valid (mg_acq_valid),
    .out_ready (mg_acq_ready),
    .out_bits  (mg_acq_bits)
  );

  assign dn_ready = fifo_in_ready;
`else
  assign dn_ready     = mg_acq_ready;
  assign mg_acq_valid = arb_valid;
  assign mg_acq_bits  = arb_bits;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      arb_owner  <= '0;
      arb_locked <= 1'b0;
    end else if (fire) begin
      case (state)
        IDLE: begin
          arb_owner <= win;
          if (is_multi_beat(sel_bits)) begin
            state      <= LOCKED;
            arb_locked <= 1'b1;
            beat_cnt   <= CNT_W'(1);
          end else begin
            rr_ptr <= next_ptr(win);
          end
        end
        LOCKED: begin
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            state      <= IDLE;
            arb_locked <= 1'b0;
            beat_cnt   <= '0;
            rr_ptr     <= next_ptr(arb_owner);
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          arb_locked <= 1'b0;
        end
      endcase
    end
  end

  // Grant demux; a dst with no matching client is accepted and dropped.
  assign gnt_dst     = mg_gnt_bits[GNT_DST_LSB +: 2];
  assign cl_gnt_bits = mg_gnt_bits;

  always_comb begin
    mg_gnt_ready = 1'b1;
    cl_gnt_valid = '0;
    for (int unsigned j = 0; j < N_CLIENTS; j++) begin
      if (gnt_dst == 2'(j)) begin
        cl_gnt_valid[j] = mg_gnt_valid;
        mg_gnt_ready    = cl_gnt_ready[j];
      end
    end
  end

endmodule

// File: tb/tb_tl_acquire_arbiter.sv
// Self-checking bench for tl_acquire_arbiter (N_CLIENTS=2, BEATS=8).
// Build with TL_ARB_PIPE_EN to exercise the pipelined acquire path instead of
// the combinational one.
module tb_tl_acquire_arbiter;

  localparam int N     = 2;
  localparam int BEATS = 8;
  localparam int AW    = 114;
  localparam int GW    = 79;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    cl_acq_valid = '0;
  logic [N-1:0]    cl_acq_ready;
  logic [N*AW-1:0] cl_acq_bits  = '0;
  logic            mg_acq_valid;
  logic            mg_acq_ready = 1'b0;
  logic [AW-1:0]   mg_acq_bits;
  logic            mg_gnt_valid = 1'b0;
  logic            mg_gnt_ready;
  logic [GW-1:0]   mg_gnt_bits  = '0;
  logic [N-1:0]    cl_gnt_valid;
  logic [N-1:0]    cl_gnt_ready = '0;
  logic [GW-1:0]   cl_gnt_bits;
  logic            arb_locked;
  logic [1:0]      arb_owner;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] req [N];

  // Reference model: next round-robin start, current burst owner and how
  // many beats of that burst are still outstanding (0 = not in a burst).
  int m_rr, m_owner, m_left;

  tl_acquire_arbiter #(
    .N_CLIENTS (N),
    .BEATS     (BEATS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cl_acq_valid (cl_acq_valid),
    .cl_acq_ready (cl_acq_ready),
    .cl_acq_bits  (cl_acq_bits),
    .mg_acq_valid (mg_acq_valid),
    .mg_acq_ready (mg_acq_ready),
    .mg_acq_bits  (mg_acq_bits),
    .mg_gnt_valid (mg_gnt_valid),
    .mg_gnt_ready (mg_gnt_ready),
    .mg_gnt_bits  (mg_gnt_bits),
    .cl_gnt_valid (cl_gnt_valid),
    .cl_gnt_ready (cl_gnt_ready),
    .cl_gnt_bits  (cl_gnt_bits),
    .arb_locked   (arb_locked),
    .arb_owner    (arb_owner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) cl_acq_bits[i*AW +: AW] = req[i];
  endtask

  function automatic logic [AW-1:0] make_acq(input bit put);
    logic [127:0]  r;
    logic [AW-1:0] b;
    r = {$urandom, $urandom, $urandom, $urandom};
    b = r[AW-1:0];
    if (put) begin
      b[79]    = 1'b1;
      b[78:76] = 3'd3;
    end else if (b[79] && b[78:76] == 3'd3) begin
      b[76] = 1'b0;
    end
    return b;
  endfunction

  function automatic bit is_put(input logic [AW-1:0] b);
    return b[79] && (b[78:76] == 3'd3);
  endfunction

  task automatic m_reset();
    m_rr    = 0;
    m_owner = 0;
    m_left  = 0;
  endtask

  // Which client the model expects on the manager port this cycle.
  function automatic int m_pick(output bit v);
    v = 1'b0;
    if (m_left > 0) begin
      v = cl_acq_valid[m_owner];
      return m_owner;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (cl_acq_valid[c]) begin
        v = 1'b1;
        return c;
      end
    end
    return 0;
  endfunction

  task automatic m_fire(input int c);
    if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_rr = (m_owner + 1) % N;
    end else begin
      m_owner = c;
      if (is_put(req[c])) m_left = BEATS - 1;
      else                m_rr   = (c + 1) % N;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    cl_acq_valid = '1;
    mg_acq_ready = 1'b1;
    for (int i = 0; i < N; i++) req[i] = make_acq(1'b0);
    apply();
    #2;
    checks++;
    if (mg_acq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mg_valid: got %b expected 0", mg_acq_valid);
    end
    checks++;
    if (cl_acq_ready !== '0) begin
      errors++; $display("FAIL reset_cl_ready: got %b expected 00", cl_acq_ready);
    end
    checks++;
    if (arb_locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %b expected 0", arb_locked);
    end
    checks++;
    if (arb_owner !== 2'd0) begin
      errors++; $display("FAIL reset_owner: got %0d expected 0", arb_owner);
    end
    @(negedge clk);
    reset        = 1'b1;
    cl_acq_valid = '0;
    tick();
    m_reset();
  endtask

  task automatic test_round_robin();
    cl_acq_valid = 2'b11;
    mg_acq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int w;
      for (int c = 0; c < N; c++) req[c] = make_acq(1'b0);
      apply();
      #2;
      w = i % 2;
      checks++;
      if (mg_acq_valid !== 1'b1) begin
        errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, mg_acq_valid);
      end
      checks++;
      if (mg_acq_bits[113:112] !== 2'(w)) begin
        errors++; $display("FAIL rr_src[%0d]: got %0d expected %0d", i, mg_acq_bits[113:112], w);
      end
      checks++;
      if (mg_acq_bits[111:0] !== req[w][111:0]) begin
        errors++; $display("FAIL rr_bits[%0d]: got %h expected %h", i, mg_acq_bits[111:0], req[w][111:0]);
      end
      checks++;
      if (cl_acq_ready !== ((w == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected winner %0d", i, cl_acq_ready, w);
      end
      m_fire(w);
      tick();
    end
    checks++;
    if (arb_owner !== 2'd1) begin
      errors++; $display("FAIL rr_owner: got %0d expected 1", arb_owner);
    end
    cl_acq_valid = '0;
  endtask

  // Client0 PutBlock against a constantly requesting client1, with the owner
  // going idle for three cycles after its third beat.
  task automatic test_burst();
    int c0 = 0;
    int drop = 0;
    bit c1done = 1'b0;
    logic [N-1:0] exp_rdy;
    req[0] = make_acq(1'b1);
    req[1] = make_acq(1'b0);
    for (int cyc = 0; cyc < 60 && !c1done; cyc++) begin
      req[0][82:80] = 3'(c0);
      if (c0 == 3 && drop < 3) begin
        cl_acq_valid[0] = 1'b0;
        drop++;
      end else begin
        cl_acq_valid[0] = (c0 < 8);
      end
      cl_acq_valid[1] = 1'b1;
      mg_acq_ready    = (cyc % 2 == 0);
      apply();
      #2;
      checks++;
      if (arb_locked !== (c0 >= 1 && c0 < 8)) begin
        errors++; $display("FAIL burst_locked[c%0d]: got %b after %0d beats", cyc, arb_locked, c0);
      end
      if (c0 >= 1) begin
        checks++;
        if (arb_owner !== 2'd0) begin
          errors++; $display("FAIL burst_owner[c%0d]: got %0d expected 0", cyc, arb_owner);
        end
      end
      if (c0 < 8) begin
        exp_rdy = (cl_acq_valid[0] && mg_acq_ready) ? 2'b01 : 2'b00;
        checks++;
        if (cl_acq_ready !== exp_rdy) begin
          errors++; $display("FAIL burst_ready[c%0d]: got %b expected %b", cyc, cl_acq_ready, exp_rdy);
        end
        checks++;
        if (mg_acq_valid !== cl_acq_valid[0]) begin
          errors++; $display("FAIL burst_mg_valid[c%0d]: got %b expected %b", cyc, mg_acq_valid, cl_acq_valid[0]);
        end
        if (cl_acq_valid[0]) begin
          checks++;
          if (mg_acq_bits[113:112] !== 2'd0) begin
            errors++; $display("FAIL burst_src[c%0d]: got %0d expected 0", cyc, mg_acq_bits[113:112]);
          end
        end
        if (exp_rdy[0]) c0++;
      end else begin
        exp_rdy = mg_acq_ready ? 2'b10 : 2'b00;
        checks++;
        if (cl_acq_ready !== exp_rdy) begin
          errors++; $display("FAIL burst_c1_ready[c%0d]: got %b expected %b", cyc, cl_acq_ready, exp_rdy);
        end
        checks++;
        if (mg_acq_bits[113:112] !== 2'd1) begin
          errors++; $display("FAIL burst_c1_src[c%0d]: got %0d expected 1", cyc, mg_acq_bits[113:112]);
        end
        if (mg_acq_ready) c1done = 1'b1;
      end
      tick();
    end
    checks++;
    if (!c1done) begin
      errors++; $display("FAIL burst_done: got %0d client0 beats and no client1 fire, expected 8 then client1", c0);
    end
    cl_acq_valid = '0;
    m_owner = 1;
    m_rr    = 0;
    m_left  = 0;
  endtask

  task automatic test_reset_mid_burst();
    cl_acq_valid = 2'b01;
    mg_acq_ready = 1'b1;
    req[0] = make_acq(1'b1);
    apply();
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++;
    if (arb_locked !== 1'b1) begin
      errors++; $display("FAIL mid_pre_locked: got %b expected 1", arb_locked);
    end
    req[1] = make_acq(1'b0);
    cl_acq_valid = 2'b11;
    apply();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (arb_locked !== 1'b0) begin
      errors++; $display("FAIL mid_rst_locked: got %b expected 0", arb_locked);
    end
    checks++;
    if (arb_owner !== 2'd0) begin
      errors++; $display("FAIL mid_rst_owner: got %0d expected 0", arb_owner);
    end
    checks++;
    if (mg_acq_valid !== 1'b0 || cl_acq_ready !== 2'b00) begin
      errors++; $display("FAIL mid_rst_handshake: got valid %b ready %b expected 0 00", mg_acq_valid, cl_acq_ready);
    end
    #1 reset = 1'b1;
    req[0] = make_acq(1'b0);
    apply();
    #1;
    m_reset();
    checks++;
    if (mg_acq_bits[113:112] !== 2'd0 || cl_acq_ready !== 2'b01) begin
      errors++; $display("FAIL mid_restart0: got src %0d ready %b expected 0 01", mg_acq_bits[113:112], cl_acq_ready);
    end
    m_fire(0);
    tick();
    #1;
    checks++;
    if (mg_acq_bits[113:112] !== 2'd1 || cl_acq_ready !== 2'b10) begin
      errors++; $display("FAIL mid_restart1: got src %0d ready %b expected 1 10", mg_acq_bits[113:112], cl_acq_ready);
    end
    m_fire(1);
    tick();
    cl_acq_valid = '0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int w;
      bit v;
      logic [N-1:0]  exp_rdy;
      logic [AW-1:0] exp_bits;
      logic [95:0]   g;
      logic [1:0]    dst;
      logic [N-1:0]  exp_gv;
      logic          exp_gr;
      for (int i = 0; i < N; i++) begin
        cl_acq_valid[i] = ($urandom_range(0, 9) < 7);
        req[i] = make_acq($urandom_range(0, 3) == 0);
      end
      mg_acq_ready = ($urandom_range(0, 3) != 0);
      g            = {$urandom, $urandom, $urandom};
      mg_gnt_bits  = g[GW-1:0];
      mg_gnt_valid = $urandom_range(0, 1) == 1;
      cl_gnt_ready = N'($urandom);
      apply();
      #2;
      w = m_pick(v);
      exp_rdy = '0;
      if (v && mg_acq_ready) exp_rdy[w] = 1'b1;
      checks++;
      if (mg_acq_valid !== v) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, mg_acq_valid, v);
      end
      checks++;
      if (cl_acq_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, cl_acq_ready, exp_rdy);
      end
      checks++;
      if (arb_locked !== (m_left > 0)) begin
        errors++; $display("FAIL rand_locked[%0d]: got %b expected %b", cyc, arb_locked, (m_left > 0));
      end
      checks++;
      if (arb_owner !== 2'(m_owner)) begin
        errors++; $display("FAIL rand_owner[%0d]: got %0d expected %0d", cyc, arb_owner, m_owner);
      end
      if (v) begin
        exp_bits = req[w];
        exp_bits[113:112] = 2'(w);
        checks++;
        if (mg_acq_bits !== exp_bits) begin
          errors++; $display("FAIL rand_bits[%0d]: got %h expected %h", cyc, mg_acq_bits, exp_bits);
        end
      end
      dst    = mg_gnt_bits[76:75];
      exp_gv = '0;
      exp_gr = 1'b1;
      if (int'(dst) < N) begin
        exp_gv[dst] = mg_gnt_valid;
        exp_gr      = cl_gnt_ready[dst];
      end
      checks++;
      if (cl_gnt_valid !== exp_gv || mg_gnt_ready !== exp_gr) begin
        errors++; $display("FAIL rand_gnt[%0d]: got valid %b ready %b expected %b %b", cyc, cl_gnt_valid, mg_gnt_ready, exp_gv, exp_gr);
      end
      checks++;
      if (cl_gnt_bits !== g[GW-1:0]) begin
        errors++; $display("FAIL rand_gnt_bits[%0d]: got %h expected %h", cyc, cl_gnt_bits, g[GW-1:0]);
      end
      if (v && mg_acq_ready) m_fire(w);
      tick();
    end
    cl_acq_valid = '0;
    mg_gnt_valid = 1'b0;
  endtask

  task automatic test_pipe();
    logic [AW-1:0] first;
    cl_acq_valid = 2'b01;
    mg_acq_ready = 1'b0;
    req[0] = make_acq(1'b0);
    first  = req[0];
    first[113:112] = 2'd0;
    apply();
    #2;
    checks++;
    if (mg_acq_valid !== 1'b0) begin
      errors++; $display("FAIL pipe_latency: got valid %b expected 0 before first edge", mg_acq_valid);
    end
    checks++;
    if (cl_acq_ready !== 2'b01) begin
      errors++; $display("FAIL pipe_accept0: got %b expected 01", cl_acq_ready);
    end
    tick();
    checks++;
    if (mg_acq_valid !== 1'b1 || mg_acq_bits !== first) begin
      errors++; $display("FAIL pipe_head: got valid %b bits %h expected 1 %h", mg_acq_valid, mg_acq_bits, first);
    end
    req[0] = make_acq(1'b0);
    apply();
    #2;
    checks++;
    if (cl_acq_ready !== 2'b01) begin
      errors++; $display("FAIL pipe_accept1: got %b expected 01", cl_acq_ready);
    end
    tick();
    req[0] = make_acq(1'b0);
    apply();
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (cl_acq_ready !== 2'b00) begin
        errors++; $display("FAIL pipe_stall[%0d]: got %b expected 00", i, cl_acq_ready);
      end
      checks++;
      if (mg_acq_bits !== first) begin
        errors++; $display("FAIL pipe_hold[%0d]: got %h expected %h", i, mg_acq_bits, first);
      end
      tick();
    end
    cl_acq_valid = '0;
    mg_acq_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (mg_acq_valid !== 1'b0) begin
      errors++; $display("FAIL pipe_drain: got %b expected 0", mg_acq_valid);
    end
    mg_acq_ready = 1'b0;
  endtask

  task automatic test_grant();
    logic [1:0]   dsts  [4] = '{2'd1, 2'd0, 2'd3, 2'd1};
    logic [N-1:0] rdys  [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
    logic [N-1:0] exp_v [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    logic         exp_r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      logic [95:0] g;
      g = {$urandom, $urandom, $urandom};
      g[76:75]     = dsts[i];
      mg_gnt_bits  = g[GW-1:0];
      mg_gnt_valid = 1'b1;
      cl_gnt_ready = rdys[i];
      #2;
      checks++;
      if (cl_gnt_valid !== exp_v[i]) begin
        errors++; $display("FAIL gnt_valid[%0d]: got %b expected %b", i, cl_gnt_valid, exp_v[i]);
      end
      checks++;
      if (mg_gnt_ready !== exp_r[i]) begin
        errors++; $display("FAIL gnt_ready[%0d]: got %b expected %b", i, mg_gnt_ready, exp_r[i]);
      end
      checks++;
      if (cl_gnt_bits !== g[GW-1:0]) begin
        errors++; $display("FAIL gnt_bits[%0d]: got %h expected %h", i, cl_gnt_bits, g[GW-1:0]);
      end
      tick();
    end
    mg_gnt_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) req[i] = '0;
    m_reset();
    test_reset();
`ifdef TL_ARB_PIPE_EN
    test_pipe();
`else
    test_round_robin();
    test_burst();
    test_reset_mid_burst();
    test_random();
`endif
    test_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
